seg_scan_ctrl: RTL and testbench

Refresh scheduler and frame-buffer controller for the multiplexed 7-segment display on the 50 MHz board.

- Holds one segment pattern per digit in a double-buffered register file that upstream logic loads through a valid/ready write port.
- Scans the digits in a fixed order with per-slot anti-ghost blanking and 16-level brightness.
- Drives the active-low DIGIT strobes and active-high SEG lines directly.
- Publishes new patterns only at frame boundaries, so the display never tears.

---
 rtl/seg_scan_ctrl_if.sv | 25 ++
 rtl/seg_scan_ctrl.sv | 114 +++++++++++
 tb/tb_seg_scan_ctrl.sv | 179 +++++++++++++++++
 3 files changed

// File: rtl/seg_scan_ctrl_if.sv
// Upstream-facing port of the display controller: frame-buffer write
// handshake plus the commit request/acknowledge pair.
interface seg_scan_ctrl_if #(
  parameter int NUM_DIGITS = 3,
  parameter int NUM_SEGS   = 8
);
  localparam int AW = $clog2(NUM_DIGITS);

  logic                WR_VALID;
  logic                WR_READY;
  logic [AW-1:0]       WR_ADDR;
  logic [NUM_SEGS-1:0] WR_DATA;
  logic                COMMIT;
  logic                COMMIT_DONE;

  modport master (
    output WR_VALID, WR_ADDR, WR_DATA, COMMIT,
    input  WR_READY, COMMIT_DONE
  );

  modport slave (
    input  WR_VALID, WR_ADDR, WR_DATA, COMMIT,
    output WR_READY, COMMIT_DONE
  );
endinterface

// File: rtl/seg_scan_ctrl.sv
// Multiplexed 7-segment refresh scheduler with a double-buffered pattern
// store. Patterns are published to the scanned buffer only at a frame
// boundary so a frame never mixes old and new data.
module seg_scan_ctrl #(
  parameter int NUM_DIGITS = 3,
  parameter int NUM_SEGS   = 8,
  parameter int DIV_WIDTH  = 16
) (
  input  logic                  OSC_50M,
  input  logic                  RESET,
  seg_scan_ctrl_if.slave        bus,
  input  logic [3:0]            BRIGHT,
  output logic                  FRAME_START,
  output logic [NUM_DIGITS-1:0] DIGIT,
  output logic [NUM_SEGS-1:0]   SEG
);
  localparam int AW = $clog2(NUM_DIGITS);

  typedef enum logic {IDLE, PENDING} state_t;

  state_t              state, state_nxt;
  logic                copy;
  logic [DIV_WIDTH-1:0] cnt;
  logic [AW-1:0]       idx;
  logic [3:0]          bright_q;
  logic [NUM_SEGS-1:0] shadow [NUM_DIGITS];
  logic [NUM_SEGS-1:0] active [NUM_DIGITS];

  logic       cnt_max, last_dig, boundary, wr_fire, lit;
  logic [3:0] sub;

  assign cnt_max  = &cnt;
  assign last_dig = (idx == AW'(NUM_DIGITS - 1));
  assign boundary = cnt_max && last_dig;
  assign sub      = cnt[DIV_WIDTH-1 -: 4];
  // Sub-period 0 stays dark so the previous digit's segments never ghost.
  assign lit      = (sub != 4'd0) && (sub <= bright_q);

  assign bus.WR_READY = (state == IDLE) && !RESET;
  // Out-of-range addresses complete the handshake but touch nothing.
  assign wr_fire = bus.WR_VALID && bus.WR_READY &&
                   ({1'b0, bus.WR_ADDR} < (AW+1)'(NUM_DIGITS));

  // Slot counter and digit index; idx steps once per slot and wraps per frame.
  always_ff @(posedge OSC_50M) begin
    if (RESET) begin
      cnt <= '0;
      idx <= '0;
    end else begin
      cnt <= cnt + DIV_WIDTH'(1);
      if (cnt_max) idx <= last_dig ? '0 : idx + AW'(1);
    end
  end

  // Commit FSM state register.
  always_ff @(posedge OSC_50M) begin
    if (RESET) state <= IDLE;
    else       state <= state_nxt;
  end

  // Commit FSM: arm on COMMIT, publish on the next frame boundary.
  always_comb begin
    state_nxt = state;
    copy      = 1'b0;
    case (state)
      IDLE:    if (bus.COMMIT) state_nxt = PENDING;
      PENDING: if (boundary) begin
        copy      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Shadow takes writes only while IDLE; active is refreshed from it at commit.
  always_ff @(posedge OSC_50M) begin
    if (RESET) begin
      for (int i = 0; i < NUM_DIGITS; i++) begin
        shadow[i] <= '0;
        active[i] <= '0;
      end
    end else begin
      if (wr_fire) shadow[bus.WR_ADDR] <= bus.WR_DATA;
      if (copy) begin
        for (int i = 0; i < NUM_DIGITS; i++) active[i] <= shadow[i];
      end
    end
  end

  // Frame-boundary pulses and brightness latch, all aligned to the same edge.
  always_ff @(posedge OSC_50M) begin
    if (RESET) begin
      FRAME_START     <= 1'b0;
      bus.COMMIT_DONE <= 1'b0;
      bright_q        <= '0;
    end else begin
      FRAME_START     <= boundary;
      bus.COMMIT_DONE <= copy;
      if (boundary) bright_q <= BRIGHT;
    end
  end

  // Registered pin drive: one active-low strobe at most, segments gated by lit.
  always_ff @(posedge OSC_50M) begin
    if (RESET) begin
      DIGIT <= '1;
      SEG   <= '0;
    end else begin
      for (int d = 0; d < NUM_DIGITS; d++)
        DIGIT[d] <= !(lit && (idx == AW'(d)));
      SEG <= lit ? active[idx] : '0;
    end
  end
endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Randomized bench for seg_scan_ctrl against a time-indexed reference model:
// position in the frame is derived from cycles since reset, not a counter copy.
module tb_seg_scan_ctrl;
  localparam int ND    = 3;
  localparam int NS    = 8;
  localparam int DW    = 4;
  localparam int SLOT  = 1 << DW;
  localparam int FRAME = ND * SLOT;

  logic          clk = 1'b0;
  logic          rst;
  logic [3:0]    bright;
  logic          fs;
  logic [ND-1:0] digit;
  logic [NS-1:0] seg;

  seg_scan_ctrl_if #(.NUM_DIGITS(ND), .NUM_SEGS(NS)) bus ();

  seg_scan_ctrl #(.NUM_DIGITS(ND), .NUM_SEGS(NS), .DIV_WIDTH(DW)) dut (
    .OSC_50M     (clk),
    .RESET       (rst),
    .bus         (bus),
    .BRIGHT      (bright),
    .FRAME_START (fs),
    .DIGIT       (digit),
    .SEG         (seg)
  );

  always #10 clk = ~clk;

  // reference model state
  int            t;
  logic [NS-1:0] m_sh [ND];
  logic [NS-1:0] m_ac [ND];
  bit            m_pend;
  int            m_bq;
  logic [ND-1:0] e_dig;
  logic [NS-1:0] e_seg;
  bit            e_fs, e_cd;

  int n_chk = 0, n_err = 0;
  int cd_count, lit_count;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // One clock edge of the behavioural model, using the inputs held across it.
  task automatic model_edge();
    int pos, slot, sub;
    bit boundary, lit;
    if (rst) begin
      t = 0;
      for (int i = 0; i < ND; i++) begin m_sh[i] = '0; m_ac[i] = '0; end
      m_pend = 0; m_bq = 0;
      e_dig = '1; e_seg = '0; e_fs = 0; e_cd = 0;
    end else begin
      pos      = t % FRAME;
      slot     = pos / SLOT;
      sub      = ((pos % SLOT) * 16) / SLOT;
      boundary = (pos == FRAME - 1);
      lit      = (sub >= 1) && (sub <= m_bq);
      e_dig    = lit ? ~(ND'(1) << slot) : '1;
      e_seg    = lit ? m_ac[slot] : '0;
      if (bus.WR_VALID && !m_pend && int'(bus.WR_ADDR) < ND) m_sh[bus.WR_ADDR] = bus.WR_DATA;
      e_cd = m_pend && boundary;
      if (e_cd) for (int i = 0; i < ND; i++) m_ac[i] = m_sh[i];
      e_fs = boundary;
      if (boundary) m_bq = int'(bright);
      if (e_cd) m_pend = 0;
      else if (!m_pend && bus.COMMIT) m_pend = 1;
      t++;
    end
  endtask

  // Called at a negedge with inputs already driven; returns at the next negedge.
  task automatic tick();
    #1;
    chk("wr_ready", 32'(bus.WR_READY), 32'(!rst && !m_pend));
    @(posedge clk);
    model_edge();
    @(negedge clk);
    chk("digit", 32'(digit), 32'(e_dig));
    chk("seg", 32'(seg), 32'(e_seg));
    chk("frame_start", 32'(fs), 32'(e_fs));
    chk("commit_done", 32'(bus.COMMIT_DONE), 32'(e_cd));
    chk("one_digit_low", 32'($countones(~digit) <= 1), 32'(1));
    if (bus.COMMIT_DONE) cd_count++;
    if (digit != '1) lit_count++;
  endtask

  task automatic idle_in();
    bus.WR_VALID = 0; bus.COMMIT = 0; bus.WR_ADDR = '0; bus.WR_DATA = '0;
  endtask

  task automatic wr(input int a, input int d);
    bus.WR_VALID = 1; bus.WR_ADDR = 2'(a); bus.WR_DATA = 8'(d);
    tick();
    bus.WR_VALID = 0;
  endtask

  initial begin
    m_pend = 0;
    rst = 1; bright = 4'hF; idle_in();
    bus.WR_VALID = 1; bus.COMMIT = 1;
    // reset held with junk on the inputs
    repeat (3) tick();
    rst = 0; idle_in();
    // first frame must be dark (bright_q cleared)
    lit_count = 0;
    repeat (FRAME) tick();
    chk("first_frame_dark", 32'(lit_count), 32'(0));

    // load three patterns and commit at full brightness
    bright = 4'd15;
    wr(0, 8'h3F); wr(1, 8'h06); wr(2, 8'h5B);
    cd_count = 0;
    bus.COMMIT = 1; tick(); bus.COMMIT = 0;
    repeat (3 * FRAME) tick();
    chk("commit_once", 32'(cd_count), 32'(1));

    // brightness 4: 4 lit clocks per slot
    bright = 4'd4;
    repeat (FRAME + 2) tick();
    lit_count = 0;
    repeat (FRAME) tick();
    chk("bright4_duty", 32'(lit_count), 32'(4 * ND));
    bright = 4'd0;
    repeat (FRAME + 2) tick();
    lit_count = 0;
    repeat (FRAME) tick();
    chk("bright0_dark", 32'(lit_count), 32'(0));

    // commit mid-frame with writes hammering and a second COMMIT while pending
    bright = 4'd15;
    repeat (7) tick();
    cd_count = 0;
    bus.COMMIT = 1; tick(); bus.COMMIT = 0;
    bus.WR_VALID = 1; bus.WR_ADDR = 2'd0; bus.WR_DATA = 8'h77;
    repeat (10) tick();
    bus.COMMIT = 1; tick(); bus.COMMIT = 0;
    repeat (FRAME) tick();
    bus.WR_VALID = 0;
    repeat (FRAME) tick();
    chk("pending_single_done", 32'(cd_count), 32'(1));

    // writes without commit, including the out-of-range address
    wr(3, 8'hFF); wr(1, 8'h11); wr(2, 8'h22);
    repeat (2 * FRAME) tick();

    // reset while pending drops the commit
    cd_count = 0;
    bus.COMMIT = 1; tick(); bus.COMMIT = 0;
    repeat (5) tick();
    rst = 1; tick(); tick(); rst = 0;
    repeat (3 * FRAME) tick();
    chk("reset_drops_commit", 32'(cd_count), 32'(0));

    // randomized traffic
    for (int n = 0; n < 4000; n++) begin
      rst          = ($urandom_range(0, 399) == 0);
      bus.WR_VALID = $urandom_range(0, 1) == 1;
      bus.WR_ADDR  = 2'($urandom_range(0, 3));
      bus.WR_DATA  = 8'($urandom);
      bus.COMMIT   = ($urandom_range(0, 29) == 0);
      if ($urandom_range(0, 63) == 0) bright = 4'($urandom);
      tick();
    end
    rst = 0; idle_in();
    repeat (4) tick();

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
